delayline_mc: RTL and testbench
===============================

// Module: delayline_mc
// PURPOSE
//   Multi-channel, variable-latency delay line for aligning parallel video signal paths (luma, chroma,
//   sync) in the composite encoder. All CHANNELS lanes share one write/read pointer pair, so they stay
//   sample-aligned. Supports a clock enable, reloading latency with a strobe, and an output-valid flag
//   so that a latency change never replays stale memory as if it were valid data.
// PARAMETERS
//   BIT_WIDTH     8   bits per channel
//   CHANNELS      3   number of parallel lanes
//   SIZE          5   address width; memory depth 2**SIZE; max latency 2**SIZE-1
//   LATENCY_INIT  1   latency_reg value after reset (1..2**SIZE-1)
// PORTS
//   clk          in   1                   system clock, all logic posedge
//   rst          in   1                   asynchronous reset, active-high
//   en           in   1                   sample enable; pipeline advances only when high
//   latency      in   SIZE                requested latency, sampled on latency_load
//   latency_load in   1                   strobe: load latency into latency_reg
//   in           in   CHANNELS*BIT_WIDTH  packed input, lane k = in[k*BIT_WIDTH +: BIT_WIDTH]
//   out          out  CHANNELS*BIT_WIDTH  registered delayed output, same packing
//   out_valid    out  1                   out carries data written since last reset/load
// BEHAVIOUR
//   - Reset (async, rst=1): wr_ptr=0, fill_cnt=0, latency_reg=LATENCY_INIT, out=0, out_valid=0.
//     The memory is not reset; validity is tracked by fill_cnt only.
//   - Cycle with en=1: mem[wr_ptr] <= in; out <= mem[rd_addr]; wr_ptr <= wr_ptr+1 (wraps mod 2**SIZE).
//     rd_addr = (wr_ptr - latency_reg) mod 2**SIZE (SIZE-bit subtraction, natural wrap).
//   - Cycle with en=0: memory, pointers, out, fill_cnt and out_valid hold their values.
//   - Latency: a sample presented with en=1 appears on out after exactly latency_reg+1 enabled cycles.
//     With continuous en, this is latency_reg+1 clk cycles.
//   - Clamp: a latency input of 0 is loaded as 1. The write and read addresses therefore never coincide.
//   - latency_load=1 (independent of en):
//     latency_reg <= clamp(latency); fill_cnt <= 0; out_valid <= 0.
//     If en=1 in the same cycle, the write still occurs and the read uses the OLD latency_reg.
//     The new latency applies from the next cycle.
//   - fill_cnt (SIZE+1 bits): increments on each en=1 cycle without load, saturating at latency_reg+1.
//     out_valid <= 1 on the enabled cycle in which fill_cnt reaches latency_reg+1.
//     In that same cycle, out receives the first sample written after reset/load.
//   - Wrap-around: pointers wrap freely. At maximum latency (2**SIZE-1), one slot is read in the
//     same cycle it would next be written, and the read returns the old content.
//   - Reset asserted mid-stream: all state above returns to reset values immediately.
//     Output is invalid until latency_reg+1 enabled cycles after rst deasserts.
// CONFIGURATION
//   DELAYLINE_ZERO_INVALID_EN
//     defined:   out is forced to 0 (registered) in every enabled cycle where the resulting
//                out_valid is 0, so downstream sees black/blank during a refill.
//     undefined: out always takes raw mem[rd_addr]; out_valid is advisory only.
//     out_valid timing is identical in both builds.
// TESTING
//   1. Reset; LATENCY_INIT=1; en=1; in = ramp 1,2,3,...
//      -> out_valid rises on the 2nd edge after reset release; out = ramp delayed by 2 cycles.
//   2. Load latency=10, then drive ramp with continuous en on 3 lanes (lane k = ramp+k*64).
//      -> out_valid low for 11 cycles; each lane's out equals its input from 11 cycles earlier.
//   3. Load latency=31 (SIZE=5, maximum); drive 100 ramp samples.
//      -> delay is exactly 32 cycles, with no corruption across pointer wrap.
//   4. Load latency=0.
//      -> behaves as latency 1 (2-cycle delay); latency_reg reads 1.
//   5. Latency=4; en toggles 1,0,1,0,...
//      -> out changes only on en=1 cycles; delay is 5 enabled samples; out holds while en=0.
//   6. Load latency 4->8 mid-stream with en=1 in the load cycle; assert rst mid-stream.
//      -> load: out_valid drops next cycle and rises after 9 enabled cycles; out then shows the
//         first post-load sample. With DELAYLINE_ZERO_INVALID_EN, out=0 during the gap.
//      -> rst: out=0 and out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/delayline_mc.sv
// Multi-lane variable-latency delay line: all lanes share one write/read pointer pair.
// Build option DELAYLINE_ZERO_INVALID_EN blanks out to zero while out_valid is low.
module delayline_mc #(
   parameter int BIT_WIDTH    = 8,
   parameter int CHANNELS     = 3,
   parameter int SIZE         = 5,
   parameter int LATENCY_INIT = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic [SIZE-1:0]               latency,
   input  logic                          latency_load,
   input  logic [CHANNELS*BIT_WIDTH-1:0] in,
   output logic [CHANNELS*BIT_WIDTH-1:0] out,
   output logic                          out_valid
);

   localparam int W     = CHANNELS * BIT_WIDTH;
   localparam int DEPTH = 1 << SIZE;

   logic [W-1:0]    mem_q [DEPTH];
   logic            mem_we;

   logic [SIZE-1:0] wr_ptr_q, wr_ptr_d;
   logic [SIZE-1:0] latency_reg_q, latency_reg_d;
   logic [SIZE-1:0] latency_clamped;
   logic [SIZE-1:0] rd_addr;
   logic [SIZE:0]   fill_cnt_q, fill_cnt_d;
   logic [SIZE:0]   fill_target;
   logic [W-1:0]    out_q, out_d;
   logic            out_valid_q, out_valid_d;

   always_comb begin
      // A zero latency would make read and write hit the same slot, so it is raised to 1.
      latency_clamped = (latency == '0) ? SIZE'(1) : latency;
      rd_addr         = wr_ptr_q - latency_reg_q;
      fill_target     = {1'b0, latency_reg_q} + (SIZE+1)'(1);

      mem_we        = en;
      wr_ptr_d      = wr_ptr_q;
      latency_reg_d = latency_reg_q;
      fill_cnt_d    = fill_cnt_q;
      out_d         = out_q;
      out_valid_d   = out_valid_q;

      if (en) begin
         wr_ptr_d = wr_ptr_q + SIZE'(1);
         out_d    = mem_q[rd_addr];
      end

      // The read in a load cycle still uses the old latency; the new one applies next cycle.
      if (latency_load) begin
         latency_reg_d = latency_clamped;
         fill_cnt_d    = '0;
         out_valid_d   = 1'b0;
      end else if (en) begin
         if (fill_cnt_q != fill_target) begin
            fill_cnt_d = fill_cnt_q + (SIZE+1)'(1);
         end
         out_valid_d = (fill_cnt_d == fill_target);
      end

`ifdef DELAYLINE_ZERO_INVALID_EN
      if (en && !out_valid_d) begin
         out_d = '0;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         latency_reg_q <= SIZE'(LATENCY_INIT);
         fill_cnt_q    <= '0;
         out_q         <= '0;
         out_valid_q   <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         latency_reg_q <= latency_reg_d;
         fill_cnt_q    <= fill_cnt_d;
         out_q         <= out_d;
         out_valid_q   <= out_valid_d;
      end
   end

   // Sample storage is never reset; fill_cnt alone decides whether out is trustworthy.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= in;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;

   a_no_collide: assert property (@(posedge clk) disable iff (rst) rd_addr != wr_ptr_q);
   a_fill_bound: assert property (@(posedge clk) disable iff (rst) fill_cnt_q <= fill_target);

endmodule

// File: tb/tb_delayline_mc.sv
// Directed bench for delayline_mc: ramps at several latencies, en gating, reloads and async reset.
module tb_delayline_mc;
   localparam int BW = 8;
   localparam int CH = 3;
   localparam int SZ = 5;
   localparam int W  = BW * CH;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic [SZ-1:0] latency = '0;
   logic          latency_load = 1'b0;
   logic [W-1:0]  in = '0;
   logic [W-1:0]  out;
   logic          out_valid;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [W-1:0] hist[$];
   int           lat_m = 1;
   int           since_m = 0;
   logic [W-1:0] m_out = '0;
   logic         m_known = 1'b1;
   logic         m_valid = 1'b0;

   delayline_mc #(.BIT_WIDTH(BW), .CHANNELS(CH), .SIZE(SZ), .LATENCY_INIT(1)) dut (
      .clk(clk), .rst(rst), .en(en), .latency(latency), .latency_load(latency_load),
      .in(in), .out(out), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] ramp(input int n);
      return {BW'(n + 128), BW'(n + 64), BW'(n)};
   endfunction

   // One clock: drive inputs, advance model, check after the edge.
   task automatic cycle(input string tag, input logic e, input logic ld, input int lv,
                        input logic [W-1:0] d);
      en = e; latency_load = ld; latency = SZ'(lv); in = d;
      @(posedge clk); #1;
      if (e) hist.push_back(d);
      if (ld) begin
         m_valid = 1'b0;
         since_m = 0;
`ifdef DELAYLINE_ZERO_INVALID_EN
         if (e) begin m_out = '0; m_known = 1'b1; end
`else
         if (e) m_known = 1'b0;
`endif
         lat_m = (lv == 0) ? 1 : lv;
      end else if (e) begin
         since_m++;
         m_valid = (since_m >= lat_m + 1);
         if (m_valid) begin
            m_out = hist[hist.size() - 1 - lat_m];
            m_known = 1'b1;
         end else begin
`ifdef DELAYLINE_ZERO_INVALID_EN
            m_out = '0; m_known = 1'b1;
`else
            m_known = 1'b0;
`endif
         end
      end
      check_vec({tag, "_valid"}, W'(out_valid), W'(m_valid));
      if (m_known) check_vec({tag, "_out"}, out, m_out);
   endtask

   task automatic model_reset();
      lat_m = 1; since_m = 0; m_out = '0; m_known = 1'b1; m_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      #12;
      check_vec("rst_out", out, '0);
      check_vec("rst_valid", W'(out_valid), '0);
      check_vec("rst_latency", W'(dut.latency_reg_q), W'(1));
      @(posedge clk); #1;
      rst = 1'b0;

      // 1: LATENCY_INIT=1, ramp 1,2,3...
      for (int n = 1; n <= 8; n++) begin
         cycle("t1", 1'b1, 1'b0, 0, ramp(n));
         if (n == 1) check_vec("t1_first_invalid", W'(out_valid), '0);
         if (n == 2) begin
            check_vec("t1_rise", W'(out_valid), W'(1));
            check_vec("t1_first_out", out, ramp(1));
         end
         if (n == 5) check_vec("t1_delay2", out, ramp(4));
      end

      // 2: latency 10, three lanes offset by 64
      cycle("t2_load", 1'b0, 1'b1, 10, '0);
      for (int n = 0; n < 30; n++) begin
         cycle("t2", 1'b1, 1'b0, 0, ramp(n));
         if (n == 9)  check_vec("t2_still_invalid", W'(out_valid), '0);
         if (n == 10) check_vec("t2_first_out", out, ramp(0));
         if (n == 20) check_vec("t2_lane_out", out, {8'd138, 8'd74, 8'd10});
      end

      // 3: maximum latency across pointer wrap
      cycle("t3_load", 1'b0, 1'b1, 31, '0);
      for (int n = 0; n < 100; n++) begin
         cycle("t3", 1'b1, 1'b0, 0, ramp(n + 3));
         if (n == 30) check_vec("t3_invalid", W'(out_valid), '0);
         if (n == 31) check_vec("t3_first_out", out, ramp(3));
         if (n == 99) check_vec("t3_wrap_out", out, ramp(71));
      end

      // 4: latency 0 is clamped to 1
      cycle("t4_load", 1'b1, 1'b1, 0, ramp(200));
      check_vec("t4_latency_reg", W'(dut.latency_reg_q), W'(1));
      for (int n = 0; n < 6; n++) begin
         cycle("t4", 1'b1, 1'b0, 0, ramp(n + 50));
         if (n == 1) check_vec("t4_delay2", out, ramp(50));
      end

      // 5: latency 4 with en toggling
      cycle("t5_load", 1'b0, 1'b1, 4, '0);
      for (int n = 0; n < 24; n++) begin
         cycle("t5", (n % 2) == 0, 1'b0, 0, ramp(n + 90));
         if (n == 8) check_vec("t5_first_out", out, ramp(90));
         if (n == 9) check_vec("t5_hold", out, ramp(90));
      end

      // 6: reload 4 -> 8 mid-stream with en=1, then async reset
      cycle("t6_load4", 1'b0, 1'b1, 4, '0);
      for (int n = 0; n < 8; n++) cycle("t6a", 1'b1, 1'b0, 0, ramp(n + 20));
      cycle("t6_load8", 1'b1, 1'b1, 8, ramp(28));
      check_vec("t6_drop", W'(out_valid), '0);
      for (int n = 0; n < 12; n++) begin
         cycle("t6b", 1'b1, 1'b0, 0, ramp(n + 29));
         if (n == 7) check_vec("t6_gap", W'(out_valid), '0);
         if (n == 8) check_vec("t6_first_post_load", out, ramp(29));
      end
      #3;
      rst = 1'b1;
      #1;
      check_vec("t6_rst_out", out, '0);
      check_vec("t6_rst_valid", W'(out_valid), '0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      for (int n = 0; n < 4; n++) cycle("t6c", 1'b1, 1'b0, 0, ramp(n + 150));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
